bp_fe_bp_update_ctrl: RTL and testbench
=======================================

// Module: bp_fe_bp_update_ctrl
// PURPOSE
//  Companion to the gshare predictor: drives its read port (r_v/idx_r) at fetch, records each
//  prediction in an in-order outstanding-branch queue, and at branch resolution pops the head and
//  drives the predictor's write port (w_v/idx_w/correct). Sits between fetch/backend and predictor.
//  Also keeps saturating branch/mispredict statistics counters.
// PARAMETERS
//  bht_idx_width_p     "inv"  predictor index width; must match the predictor instance
//  queue_els_p         8      outstanding-branch queue depth, power of 2, >=2
//  stat_width_p        32     width of statistics counters
//  flush_on_mispred_p  1      1: a mispredicting resolution squashes all younger queue entries
// PORTS
//  clk_i            in   1                 clock
//  reset_n_i        in   1                 asynchronous active-low reset
//  fetch_v_i        in   1                 fetch presents a branch needing prediction
//  fetch_idx_i      in   bht_idx_width_p   branch PC index
//  fetch_ready_o    out  1                 queue can accept (~full)
//  pred_taken_o     out  1                 prediction returned to fetch (comb.)
//  pred_tag_o       out  log2(queue_els_p) queue slot of the accepted branch (comb.)
//  r_v_o            out  1                 to predictor r_v_i
//  idx_r_o          out  bht_idx_width_p   to predictor idx_r_i
//  predict_i        in   1                 from predictor predict_o
//  resolve_v_i      in   1                 oldest outstanding branch resolved
//  resolve_taken_i  in   1                 actual direction of that branch
//  flush_i          in   1                 external pipeline flush: drop all entries
//  w_v_o            out  1                 to predictor w_v_i (registered)
//  idx_w_o          out  bht_idx_width_p   to predictor idx_w_i (registered)
//  correct_o        out  1                 to predictor correct_i (registered)
//  mispredict_o     out  1                 pulse, same cycle as w_v_o, when correct_o=0
//  count_o          out  log2(queue_els_p)+1 current occupancy
//  branches_o       out  stat_width_p      resolved branches, saturating
//  mispreds_o       out  stat_width_p      mispredicted branches, saturating
// BEHAVIOUR
//  Reset (async assert, sync-released use): queue empty, rd/wr ptrs 0, w_v_o/correct_o/mispredict_o=0,
//   idx_w_o=0, branches_o=mispreds_o=0, fetch_ready_o=1 once reset deasserts.
//  Queue entry = {idx, predicted_taken}; ptrs are log2(depth)+1 bits, wrap naturally; full when
//   MSBs differ and rest equal; empty when equal.
//  Predict path (0-cycle): r_v_o = fetch_v_i & fetch_ready_o; idx_r_o = fetch_idx_i;
//   pred_taken_o = predict_i; pred_tag_o = wr_ptr low bits. Push {fetch_idx_i,predict_i} on clk edge
//   when r_v_o. fetch_v_i while full: no push, r_v_o=0, fetch must hold.
//  Resolve path (1-cycle): resolve_v_i with non-empty queue pops head; next cycle w_v_o=1,
//   idx_w_o=head.idx, correct_o=(resolve_taken_i==head.pred), mispredict_o=~correct_o.
//   resolve_v_i when empty: ignored, no write, flagged by assertion.
//  Simultaneous push and pop: both occur; occupancy unchanged. Push while full with a pop in the
//   same cycle is NOT allowed (ready is ~full, not ~full|pop).
//  Mispredict with flush_on_mispred_p=1: the pop and squash happen together; wr_ptr := rd_ptr+1
//   (queue empty next cycle); a push in that cycle is discarded (it is wrong-path).
//  flush_i: queue empty next cycle; any same-cycle push discarded; a same-cycle pop still produces
//   its update (resolution precedes flush). Flush does not clear stats.
//  Stats: on each pop branches_o+=1, on mispredict mispreds_o+=1; both hold at all-ones.
//  Reset mid-operation: all in-flight entries and a pending w_v_o are dropped immediately.
// TESTING
//  1 Reset, push idx 5 with predict_i=1, resolve taken=1 -> next cycle w_v_o=1 idx_w_o=5 correct_o=1.
//  2 Push 8 entries (depth 8) -> fetch_ready_o=0, count_o=8, 9th fetch_v_i gives r_v_o=0; one
//    resolve + push same cycle when count 7 -> count_o stays 7.
//  3 Push idx 1,2,3 (pred 0,1,1); resolve taken=1 on idx 1 -> correct_o=0, mispredict_o=1,
//    count_o=0 next cycle (flush_on_mispred_p=1); with param 0 count_o=2, next idx_w_o=2.
//  4 flush_i with count 4 and simultaneous resolve -> one update for head, count_o=0.
//  5 Wrap: 20 push/resolve pairs -> idx_w_o sequence equals push order; branches_o=20.
//  6 stat_width_p=3, 9 mispredicts -> mispreds_o=7; reset_n_i low mid-burst -> count_o=0, w_v_o=0.

Source files
------------

// File: rtl/bp_fe_bp_update_ctrl.sv
// Fetch/resolve glue around the gshare predictor: issues reads at fetch, keeps
// an in-order queue of outstanding predictions, and issues registered updates.
module bp_fe_bp_update_ctrl #(
    parameter int bht_idx_width_p    = 10,
    parameter int queue_els_p        = 8,
    parameter int stat_width_p       = 32,
    parameter bit flush_on_mispred_p = 1'b1,
    localparam int ptr_w_lp          = $clog2(queue_els_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,

    input  logic                       fetch_v_i,
    input  logic [bht_idx_width_p-1:0] fetch_idx_i,
    output logic                       fetch_ready_o,
    output logic                       pred_taken_o,
    output logic [ptr_w_lp-1:0]        pred_tag_o,

    output logic                       r_v_o,
    output logic [bht_idx_width_p-1:0] idx_r_o,
    input  logic                       predict_i,

    input  logic                       resolve_v_i,
    input  logic                       resolve_taken_i,
    input  logic                       flush_i,

    output logic                       w_v_o,
    output logic [bht_idx_width_p-1:0] idx_w_o,
    output logic                       correct_o,
    output logic                       mispredict_o,

    output logic [ptr_w_lp:0]          count_o,
    output logic [stat_width_p-1:0]    branches_o,
    output logic [stat_width_p-1:0]    mispreds_o
);

    typedef logic [ptr_w_lp:0]       ptr_t;
    typedef logic [stat_width_p-1:0] stat_t;

    ptr_t wr_ptr_r, rd_ptr_r, wr_ptr_n, rd_ptr_n;

    logic [bht_idx_width_p-1:0] idx_mem [queue_els_p];
    logic [queue_els_p-1:0]     pred_mem;

    logic                       full, empty, pop, squash, head_correct, head_pred;
    logic [bht_idx_width_p-1:0] head_idx;

    always_comb begin
        empty = (wr_ptr_r == rd_ptr_r);
        full  = (wr_ptr_r[ptr_w_lp] != rd_ptr_r[ptr_w_lp])
             && (wr_ptr_r[ptr_w_lp-1:0] == rd_ptr_r[ptr_w_lp-1:0]);

        fetch_ready_o = ~full;
        r_v_o         = fetch_v_i & ~full;
        idx_r_o       = fetch_idx_i;
        pred_taken_o  = predict_i;
        pred_tag_o    = wr_ptr_r[ptr_w_lp-1:0];

        head_idx     = idx_mem[rd_ptr_r[ptr_w_lp-1:0]];
        head_pred    = pred_mem[rd_ptr_r[ptr_w_lp-1:0]];
        head_correct = (resolve_taken_i == head_pred);
        pop          = resolve_v_i & ~empty;

        // Squash collapses the queue onto the post-pop head, discarding any same-cycle push.
        squash   = flush_i | (flush_on_mispred_p & pop & ~head_correct);
        rd_ptr_n = rd_ptr_r + ptr_t'(pop);
        wr_ptr_n = squash ? rd_ptr_n : wr_ptr_r + ptr_t'(r_v_o);

        count_o = wr_ptr_r - rd_ptr_r;
    end

    always_ff @(posedge clk_i) begin
        if (r_v_o) begin
            idx_mem[wr_ptr_r[ptr_w_lp-1:0]]  <= fetch_idx_i;
            pred_mem[wr_ptr_r[ptr_w_lp-1:0]] <= predict_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            w_v_o        <= 1'b0;
            idx_w_o      <= '0;
            correct_o    <= 1'b0;
            mispredict_o <= 1'b0;
            branches_o   <= '0;
            mispreds_o   <= '0;
        end else begin
            wr_ptr_r     <= wr_ptr_n;
            rd_ptr_r     <= rd_ptr_n;
            w_v_o        <= pop;
            correct_o    <= pop & head_correct;
            mispredict_o <= pop & ~head_correct;
            if (pop) begin
                idx_w_o <= head_idx;
                if (branches_o != '1)
                    branches_o <= branches_o + stat_t'(1);
                if (!head_correct && mispreds_o != '1)
                    mispreds_o <= mispreds_o + stat_t'(1);
            end
        end
    end

`ifndef SYNTHESIS
    resolve_needs_entry: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) !(resolve_v_i && empty)
    ) else $error("resolve_v_i asserted with an empty outstanding-branch queue");
`endif

endmodule

// File: tb/tb_bp_fe_bp_update_ctrl.sv
// Randomized and directed bench for bp_fe_bp_update_ctrl; two instances cover
// squash-on-mispredict on/off and narrow saturating statistics.
module tb_bp_fe_bp_update_ctrl;

    localparam int IW    = 6;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic          fetch_v [2];
    logic [IW-1:0] fetch_idx [2];
    logic          predict [2];
    logic          resolve_v [2];
    logic          resolve_taken [2];
    logic          flush [2];

    logic          fetch_ready [2];
    logic          pred_taken [2];
    logic [2:0]    pred_tag [2];
    logic          r_v [2];
    logic [IW-1:0] idx_r [2];
    logic          w_v [2];
    logic [IW-1:0] idx_w [2];
    logic          correct [2];
    logic          mispredict [2];
    logic [3:0]    cnt_o [2];
    logic [31:0]   br0, mp0;
    logic [2:0]    br1, mp1;

    bp_fe_bp_update_ctrl #(
        .bht_idx_width_p(IW), .queue_els_p(DEPTH),
        .stat_width_p(32), .flush_on_mispred_p(1'b1)
    ) dut0 (
        .clk_i(clk), .reset_n_i(reset_n),
        .fetch_v_i(fetch_v[0]), .fetch_idx_i(fetch_idx[0]), .fetch_ready_o(fetch_ready[0]),
        .pred_taken_o(pred_taken[0]), .pred_tag_o(pred_tag[0]),
        .r_v_o(r_v[0]), .idx_r_o(idx_r[0]), .predict_i(predict[0]),
        .resolve_v_i(resolve_v[0]), .resolve_taken_i(resolve_taken[0]), .flush_i(flush[0]),
        .w_v_o(w_v[0]), .idx_w_o(idx_w[0]), .correct_o(correct[0]), .mispredict_o(mispredict[0]),
        .count_o(cnt_o[0]), .branches_o(br0), .mispreds_o(mp0)
    );

    bp_fe_bp_update_ctrl #(
        .bht_idx_width_p(IW), .queue_els_p(DEPTH),
        .stat_width_p(3), .flush_on_mispred_p(1'b0)
    ) dut1 (
        .clk_i(clk), .reset_n_i(reset_n),
        .fetch_v_i(fetch_v[1]), .fetch_idx_i(fetch_idx[1]), .fetch_ready_o(fetch_ready[1]),
        .pred_taken_o(pred_taken[1]), .pred_tag_o(pred_tag[1]),
        .r_v_o(r_v[1]), .idx_r_o(idx_r[1]), .predict_i(predict[1]),
        .resolve_v_i(resolve_v[1]), .resolve_taken_i(resolve_taken[1]), .flush_i(flush[1]),
        .w_v_o(w_v[1]), .idx_w_o(idx_w[1]), .correct_o(correct[1]), .mispredict_o(mispredict[1]),
        .count_o(cnt_o[1]), .branches_o(br1), .mispreds_o(mp1)
    );

    // Reference model: plain FIFO of (idx, prediction) plus occupancy and stat totals.
    logic [IW-1:0] m_idx [2][DEPTH];
    bit            m_pred [2][DEPTH];
    int            m_head [2];
    int            m_cnt [2];
    longint        m_br [2];
    longint        m_mp [2];
    longint        m_max [2] = '{64'hFFFF_FFFF, 64'd7};
    bit            m_flush [2] = '{1'b1, 1'b0};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] stat_br(input int u);
        return (u == 0) ? {32'b0, br0} : {61'b0, br1};
    endfunction

    function automatic logic [63:0] stat_mp(input int u);
        return (u == 0) ? {32'b0, mp0} : {61'b0, mp1};
    endfunction

    task automatic idle_inputs();
        for (int k = 0; k < 2; k++) begin
            fetch_v[k] = 1'b0; fetch_idx[k] = '0; predict[k] = 1'b0;
            resolve_v[k] = 1'b0; resolve_taken[k] = 1'b0; flush[k] = 1'b0;
        end
    endtask

    // One clock on instance u; entered and left at posedge+1.
    task automatic cycle(input int u, input bit fv, input logic [IW-1:0] fi, input bit pr,
                         input bit rv, input bit rt, input bit fl);
        bit rdy, rvo, pop, sq, e_pred, e_cor;
        logic [IW-1:0] e_idx;
        int tag;
        idle_inputs();
        fetch_v[u] = fv; fetch_idx[u] = fi; predict[u] = pr;
        resolve_v[u] = rv; resolve_taken[u] = rt; flush[u] = fl;
        #1;
        rdy = (m_cnt[u] < DEPTH);
        rvo = fv && rdy;
        tag = (m_head[u] + m_cnt[u]) % DEPTH;
        chk("fetch_ready", fetch_ready[u], rdy);
        chk("r_v", r_v[u], rvo);
        chk("idx_r", idx_r[u], fi);
        chk("pred_taken", pred_taken[u], pr);
        if (rvo) chk("pred_tag", pred_tag[u], tag);

        pop = rv && (m_cnt[u] > 0);
        e_cor = 1'b1; e_idx = '0;
        if (pop) begin
            e_idx  = m_idx[u][m_head[u]];
            e_pred = m_pred[u][m_head[u]];
            e_cor  = (rt == e_pred);
            m_head[u] = (m_head[u] + 1) % DEPTH;
            m_cnt[u]--;
            if (m_br[u] < m_max[u]) m_br[u]++;
            if (!e_cor && m_mp[u] < m_max[u]) m_mp[u]++;
        end
        sq = fl || (m_flush[u] && pop && !e_cor);
        if (sq) m_cnt[u] = 0;
        else if (rvo) begin
            m_idx[u][(m_head[u] + m_cnt[u]) % DEPTH]  = fi;
            m_pred[u][(m_head[u] + m_cnt[u]) % DEPTH] = pr;
            m_cnt[u]++;
        end

        @(posedge clk); #1;
        chk("w_v", w_v[u], pop);
        chk("mispredict", mispredict[u], pop && !e_cor);
        if (pop) begin
            chk("idx_w", idx_w[u], e_idx);
            chk("correct", correct[u], e_cor);
        end
        chk("count", cnt_o[u], m_cnt[u]);
        chk("branches", stat_br(u), m_br[u]);
        chk("mispreds", stat_mp(u), m_mp[u]);
    endtask

    task automatic push(input int u, input logic [IW-1:0] fi, input bit pr);
        cycle(u, 1'b1, fi, pr, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic bit head_pred(input int u);
        return m_pred[u][m_head[u]];
    endfunction

    task automatic drain(input int u);
        while (m_cnt[u] > 0) cycle(u, 1'b0, '0, 1'b0, 1'b1, head_pred(u), 1'b0);
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_count", cnt_o[k], 0);
            chk("rst_w_v", w_v[k], 0);
            chk("rst_idx_w", idx_w[k], 0);
            chk("rst_correct", correct[k], 0);
            chk("rst_mispredict", mispredict[k], 0);
            chk("rst_branches", stat_br(k), 0);
            chk("rst_mispreds", stat_mp(k), 0);
            m_head[k] = 0; m_cnt[k] = 0; m_br[k] = 0; m_mp[k] = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        #1;
        chk("rst_ready0", fetch_ready[0], 1);
        chk("rst_ready1", fetch_ready[1], 1);
        @(posedge clk); #1;
    endtask

    initial begin
        idle_inputs();
        do_reset();

        push(0, 6'd5, 1'b1);
        cycle(0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t1_idx_w", idx_w[0], 5);
        chk("t1_correct", correct[0], 1);

        for (int i = 0; i < DEPTH; i++) push(0, IW'($urandom_range(0, 63)), 1'($urandom));
        chk("t2_full_count", cnt_o[0], DEPTH);
        push(0, 6'd9, 1'b0);
        cycle(0, 1'b0, '0, 1'b0, 1'b1, head_pred(0), 1'b0);
        cycle(0, 1'b1, 6'd33, 1'b1, 1'b1, head_pred(0), 1'b0);
        chk("t2_count_held", cnt_o[0], 7);
        drain(0);

        for (int u = 0; u < 2; u++) begin
            push(u, 6'd1, 1'b0);
            push(u, 6'd2, 1'b1);
            push(u, 6'd3, 1'b1);
            cycle(u, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        chk("t3_count_squash", cnt_o[0], 0);
        chk("t3_count_keep", cnt_o[1], 2);
        cycle(1, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t3_next_idx_w", idx_w[1], 2);
        drain(1);

        for (int i = 0; i < 4; i++) push(0, IW'($urandom_range(0, 63)), 1'($urandom));
        cycle(0, 1'b1, 6'd17, 1'b0, 1'b1, head_pred(0), 1'b1);
        chk("t4_update", w_v[0], 1);
        chk("t4_count", cnt_o[0], 0);

        do_reset();
        for (int i = 0; i < 20; i++) begin
            push(0, IW'($urandom_range(0, 63)), 1'($urandom));
            cycle(0, 1'b0, '0, 1'b0, 1'b1, 1'($urandom), 1'b0);
        end
        chk("t5_branches", br0, 20);

        do_reset();
        for (int i = 0; i < 9; i++) begin
            push(1, IW'(i), 1'b1);
            cycle(1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        chk("t6_mispreds_sat", mp1, 7);
        chk("t6_branches_sat", br1, 7);

        for (int n = 0; n < 600; n++) begin
            int u;
            bit rv;
            u  = n % 2;
            rv = (m_cnt[u] > 0) && ($urandom_range(0, 1) == 1);
            cycle(u, $urandom_range(0, 9) < 7, IW'($urandom_range(0, 63)), 1'($urandom),
                  rv, 1'($urandom), $urandom_range(0, 19) == 0);
        end

        drain(0);
        for (int i = 0; i < 3; i++) push(0, IW'(i + 40), 1'b0);
        cycle(0, 1'b1, 6'd50, 1'b0, 1'b1, 1'b0, 1'b0);
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete in time");
        $fatal(1, "timeout");
    end

endmodule
